conv_job_scheduler: RTL

Job scheduler in front of the binary-convolution controller. Accepts convolution job descriptors (input, weight and output base addresses) from the host side into a small FIFO. Launches them one at a time by driving `dut_run` and holding the base addresses stable. Tracks `dut_busy` to detect start and completion, and reports per-job done pulses plus a completed-job count.

---
 rtl/conv_job_scheduler_pkg.sv | 28 ++
 rtl/conv_job_scheduler_fifo.sv | 52 +++++
 rtl/conv_job_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/conv_job_scheduler_pkg.sv
// Shared types and defaults for the convolution job scheduler.
// The watchdog is built only when SCHED_TIMEOUT_EN is defined.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_RUN,
    S_DONE,
    S_ERR
  } sched_state_t;

  localparam int unsigned SCHED_ADDR_W_DEF  = 12;
  localparam int unsigned SCHED_TIMEOUT_DEF = 1024;

  // Descriptor at the default address width; the top builds the same layout at its own ADDR_W.
  typedef struct packed {
    logic [SCHED_ADDR_W_DEF-1:0] in_base;
    logic [SCHED_ADDR_W_DEF-1:0] wt_base;
    logic [SCHED_ADDR_W_DEF-1:0] out_base;
  } conv_desc_t;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/conv_job_scheduler_fifo.sv
// Synchronous descriptor FIFO; pointers carry one extra wrap bit to tell full from empty.
module conv_job_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [IDX_W:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read between a push and its pop.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/conv_job_scheduler.sv
// Queues convolution job descriptors and launches them one at a time on the controller.
// Optional watchdog/ERR state enabled by defining SCHED_TIMEOUT_EN.
module conv_job_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned ADDR_W  = SCHED_ADDR_W_DEF,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = SCHED_TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_in_base,
  input  logic [ADDR_W-1:0] job_wt_base,
  input  logic [ADDR_W-1:0] job_out_base,
  output logic              dut_run,
  input  logic              dut_busy,
  output logic [ADDR_W-1:0] dut_in_base,
  output logic [ADDR_W-1:0] dut_wt_base,
  output logic [ADDR_W-1:0] dut_out_base,
  output logic              job_done,
  output logic [7:0]        jobs_done_cnt,
  output logic              idle,
  output logic              err_timeout,
  input  logic              err_clear
);

  typedef struct packed {
    logic [ADDR_W-1:0] in_base;
    logic [ADDR_W-1:0] wt_base;
    logic [ADDR_W-1:0] out_base;
  } desc_t;

  localparam int unsigned DESC_W = $bits(desc_t);

  sched_state_t      state_q, state_d;
  desc_t             active_q, active_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DESC_W-1:0] fifo_wdata, fifo_rdata;
  desc_t             fifo_head;
  logic              tmr_expired;

  assign job_ready  = !fifo_full;
  assign fifo_push  = job_valid && !fifo_full;
  assign fifo_wdata = {job_in_base, job_wt_base, job_out_base};
  assign fifo_head  = desc_t'(fifo_rdata);

  conv_job_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned TMR_W = cnt_width(TIMEOUT);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;

  assign tmr_expired = (tmr_q == TMR_W'(TIMEOUT - 1));
  assign err_timeout = err_q;

  // Timer restarts whenever WAIT_BUSY or RUN is entered and counts while waiting there.
  always_comb begin
    tmr_d = tmr_q;
    err_d = err_q;
    if (state_d != state_q) begin
      tmr_d = '0;
    end else if (state_q == S_WAIT_BUSY || state_q == S_RUN) begin
      tmr_d = tmr_q + 1'b1;
    end
    if (err_clear) err_d = 1'b0;
    if (state_d == S_ERR && state_q != S_ERR) err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= err_d;
    end
  end
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;
  logic unused_err_clear;

  assign unused_err_clear = err_clear;
  assign tmr_expired      = 1'b0;
  assign err_timeout      = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          active_d = fifo_head;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (dut_busy) state_d = S_RUN;
        else if (tmr_expired) state_d = S_ERR;
      end
      S_RUN: begin
        if (!dut_busy) state_d = S_DONE;
        else if (tmr_expired) state_d = S_ERR;
      end
      S_DONE: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = S_IDLE;
      end
      S_ERR: begin
`ifdef SCHED_TIMEOUT_EN
        if (err_clear) state_d = S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      active_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  // Run is held through LAUNCH and WAIT_BUSY so it falls the cycle after busy is first seen.
  assign dut_run       = (state_q == S_LAUNCH) || (state_q == S_WAIT_BUSY);
  assign job_done      = (state_q == S_DONE);
  assign idle          = (state_q == S_IDLE) && fifo_empty;
  assign jobs_done_cnt = cnt_q;
  assign dut_in_base   = active_q.in_base;
  assign dut_wt_base   = active_q.wt_base;
  assign dut_out_base  = active_q.out_base;

endmodule
